// File: rtl/rtc_sync_ctrl.sv
// rtc_sync_ctrl
// PCF8563-class RTC controller sitting on the shared byte-wide I2C master
// (exec/done handshake). After power-up it checks the oscillator-stop flag,
// restores TIME_INI if the clock was lost, then re-reads the time fields
// every POLL_GAP cycles and publishes coherent masked-BCD snapshots. Runtime
// time-set is a req/ack handshake serviced only between read sweeps.
// Optional feature: define RTC_ALARM_EN to add alarm_time/alarm_hit.
module rtc_sync_ctrl #(
    parameter logic [47:0] TIME_INI   = 48'h18_03_19_09_30_00,
    parameter int          PWRUP_WAIT = 8000,
    parameter int          POLL_GAP   = 50000,
    parameter logic [7:0]  REG_BASE   = 8'h02
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        i2c_exec,
    output logic        i2c_rh_wl,
    output logic [15:0] i2c_addr,
    output logic [7:0]  i2c_data_w,
    input  logic [7:0]  i2c_data_r,
    input  logic        i2c_done,
    input  logic        set_req,
    input  logic [47:0] set_time,
    output logic        set_ack,
    output logic [47:0] rtc_time,
    output logic        time_valid,
    output logic        vl_flag,
`ifdef RTC_ALARM_EN
    input  logic [23:0] alarm_time,
    output logic        alarm_hit,
`endif
    output logic        busy
);

    localparam int WAIT_W = (PWRUP_WAIT < 1) ? 1 : $clog2(PWRUP_WAIT + 1);
    localparam int GAP_W  = (POLL_GAP < 1) ? 1 : $clog2(POLL_GAP + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(PWRUP_WAIT);
    localparam logic [GAP_W-1:0]  GAP_LAST   = GAP_W'(POLL_GAP);
    localparam logic [2:0]        LAST_FIELD = 3'd5;

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_CHK,
        ST_WR,
        ST_RD,
        ST_GAP,
        ST_SET
    } state_t;

    state_t             state_q, state_d;
    logic               pend_q, pend_d;
    logic [2:0]         idx_q, idx_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [47:0]        wr_buf_q, wr_buf_d;
    logic [47:0]        shadow_q, shadow_d;
    logic [47:0]        rtc_time_q, rtc_time_d;
    logic               time_valid_q, time_valid_d;
    logic               vl_flag_q, vl_flag_d;
`ifdef RTC_ALARM_EN
    logic               alarm_hit_q, alarm_hit_d;
`endif

    logic [7:0]         field_off;
    logic [7:0]         field_mask;
    logic [7:0]         rd_byte;
    logic [7:0]         wr_byte;
    logic [47:0]        snap_next;
    logic               xfer;

    // Field decode: register offset (weekday skipped), BCD mask, and the byte to write.
    always_comb begin
        field_off = {5'b00000, idx_q};
        if (idx_q >= 3'd4) begin
            field_off = field_off + 8'd1;
        end
        case (idx_q)
            3'd0, 3'd1: field_mask = 8'h7F;
            3'd2, 3'd3: field_mask = 8'h3F;
            3'd4:       field_mask = 8'h1F;
            default:    field_mask = 8'hFF;
        endcase
        rd_byte   = i2c_data_r & field_mask;
        wr_byte   = wr_buf_q[{idx_q, 3'b000} +: 8];
        snap_next = {rd_byte, shadow_q[39:0]};
    end

    // Next-state logic: sweep sequencing, one transaction in flight at a time.
    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        idx_d        = idx_q;
        wait_cnt_d   = wait_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        wr_buf_d     = wr_buf_q;
        shadow_d     = shadow_q;
        rtc_time_d   = rtc_time_q;
        time_valid_d = 1'b0;
        vl_flag_d    = vl_flag_q;
`ifdef RTC_ALARM_EN
        alarm_hit_d  = 1'b0;
`endif
        case (state_q)
            ST_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    wait_cnt_d = '0;
                    pend_d     = 1'b0;
                    idx_d      = 3'd0;
                    state_d    = ST_CHK;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_CHK: begin
                if (!pend_q) begin
                    pend_d = 1'b1;
                end else if (i2c_done) begin
                    pend_d = 1'b0;
                    idx_d  = 3'd0;
                    if (i2c_data_r[7]) begin
                        vl_flag_d = 1'b1;
                        wr_buf_d  = TIME_INI;
                        state_d   = ST_WR;
                    end else begin
                        state_d   = ST_RD;
                    end
                end
            end
            ST_WR: begin
                if (!pend_q) begin
                    pend_d = 1'b1;
                end else if (i2c_done) begin
                    pend_d = 1'b0;
                    if (idx_q == LAST_FIELD) begin
                        idx_d     = 3'd0;
                        vl_flag_d = 1'b0;
                        state_d   = ST_RD;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ST_RD: begin
                if (!pend_q) begin
                    pend_d = 1'b1;
                end else if (i2c_done) begin
                    pend_d = 1'b0;
                    shadow_d[{idx_q, 3'b000} +: 8] = rd_byte;
                    if (idx_q == LAST_FIELD) begin
                        idx_d        = 3'd0;
                        rtc_time_d   = snap_next;
                        time_valid_d = 1'b1;
`ifdef RTC_ALARM_EN
                        alarm_hit_d  = (snap_next[23:0] == alarm_time) &&
                                       (rtc_time_q[23:0] != alarm_time);
`endif
                        gap_cnt_d    = '0;
                        state_d      = ST_GAP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    idx_d     = 3'd0;
                    state_d   = set_req ? ST_SET : ST_RD;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            ST_SET: begin
                wr_buf_d = set_time;
                idx_d    = 3'd0;
                pend_d   = 1'b0;
                state_d  = ST_WR;
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase
    end

    // Bus outputs derived from registered state so they stay put from exec to done.
    always_comb begin
        xfer       = (state_q == ST_CHK) || (state_q == ST_WR) || (state_q == ST_RD);
        i2c_exec   = xfer && !pend_q;
        i2c_rh_wl  = (state_q == ST_CHK) || (state_q == ST_RD);
        i2c_addr   = 16'h0000;
        i2c_data_w = 8'h00;
        if (xfer) begin
            i2c_addr = {8'h00, REG_BASE + field_off};
        end
        if (state_q == ST_WR) begin
            i2c_data_w = wr_byte;
        end
        busy    = xfer;
        set_ack = (state_q == ST_SET);
    end

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_WAIT;
            pend_q       <= 1'b0;
            idx_q        <= 3'd0;
            wait_cnt_q   <= '0;
            gap_cnt_q    <= '0;
            wr_buf_q     <= '0;
            shadow_q     <= '0;
            rtc_time_q   <= '0;
            time_valid_q <= 1'b0;
            vl_flag_q    <= 1'b0;
`ifdef RTC_ALARM_EN
            alarm_hit_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            idx_q        <= idx_d;
            wait_cnt_q   <= wait_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            wr_buf_q     <= wr_buf_d;
            shadow_q     <= shadow_d;
            rtc_time_q   <= rtc_time_d;
            time_valid_q <= time_valid_d;
            vl_flag_q    <= vl_flag_d;
`ifdef RTC_ALARM_EN
            alarm_hit_q  <= alarm_hit_d;
`endif
        end
    end

    assign rtc_time   = rtc_time_q;
    assign time_valid = time_valid_q;
    assign vl_flag    = vl_flag_q;
`ifdef RTC_ALARM_EN
    assign alarm_hit  = alarm_hit_q;
`endif

endmodule
